// File: rtl/pmod_mux_arbiter_if.sv
// Request/grant and PMOD mux control bundle between the peripheral requesters
// and the PMOD mux arbiter.
interface pmod_mux_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] mux_sel;
    logic       port_hiz;
    logic       busy;
    logic       timeout_err;
    logic [1:0] state_dbg;

    // req is a level request; a requester keeps its bit high for as long as it
    // wants the port, and owns the pins only while its grant bit is high.
    modport master (
        output req,
        input  grant, mux_sel, port_hiz, busy, timeout_err, state_dbg
    );

    modport slave (
        input  req,
        output grant, mux_sel, port_hiz, busy, timeout_err, state_dbg
    );
endinterface

// File: rtl/pmod_mux_arbiter.sv
// Round-robin arbiter sharing one PMOD port between UART, SPI, GPIO and I2C,
// with high-Z guard cycles on every mux select change and a grant-hold timeout.
module pmod_mux_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [1:0]  RESET_SEL      = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    pmod_mux_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  mux_sel_q, mux_sel_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  guard_cnt_q, guard_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        to_done_q, to_done_d;

    logic [1:0]  rr_idx;
    logic [1:0]  rr_win;
    logic        rr_found;
    logic [3:0]  grant_vec;
    logic        timeout_hit;

    // Search starts just after the last completed grant and wraps.
    always_comb begin
        rr_idx   = '0;
        rr_win   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_grant_q + 2'(i);
            if (!rr_found && bus.req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    always_comb begin
        grant_vec   = (state_q == ST_GRANT) ? (4'b0001 << winner_q) : 4'b0000;
        timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (state_q == ST_GRANT) &&
                      (hold_cnt_q == TIMEOUT_CYCLES) &&
                      (|(bus.req & ~grant_vec)) && !to_done_q;
    end

    always_comb begin
        state_d      = state_q;
        mux_sel_d    = mux_sel_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        guard_cnt_d  = guard_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        to_done_d    = to_done_q | timeout_hit;
        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    winner_d = rr_win;
                    if (rr_win == mux_sel_q) begin
                        state_d    = ST_GRANT;
                        hold_cnt_d = '0;
                        to_done_d  = 1'b0;
                    end else begin
                        state_d     = ST_GUARD;
                        mux_sel_d   = rr_win;
                        guard_cnt_d = GUARD_LOAD;
                    end
                end
            end
            ST_GUARD: begin
                // An abandoned guard leaves last_grant alone so fairness is kept.
                if (!bus.req[winner_q]) begin
                    state_d = ST_IDLE;
                end else if (guard_cnt_q == 8'd0) begin
                    state_d    = ST_GRANT;
                    hold_cnt_d = '0;
                    to_done_d  = 1'b0;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            ST_GRANT: begin
                if (!bus.req[winner_q]) begin
                    state_d      = ST_IDLE;
                    last_grant_d = winner_q;
                end else if (hold_cnt_q != TIMEOUT_CYCLES) begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mux_sel_q    <= RESET_SEL;
            last_grant_q <= 2'd3;
            winner_q     <= 2'd0;
            guard_cnt_q  <= 8'd0;
            hold_cnt_q   <= 16'd0;
            to_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mux_sel_q    <= mux_sel_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            guard_cnt_q  <= guard_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            to_done_q    <= to_done_d;
        end
    end

    assign bus.grant       = grant_vec;
    assign bus.mux_sel     = mux_sel_q;
    assign bus.port_hiz    = (state_q == ST_GUARD);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.timeout_err = timeout_hit;
    assign bus.state_dbg   = state_q;

endmodule
